// File: rtl/axis_skid_pkg.sv
// Shared types and constants for the AXI4-Stream skid pipeline.
package axis_skid_pkg;

    // Upper bound on the number of series stages.
    localparam int STAGES_MAX  = 8;
    // Width of the default beat layout below.
    localparam int DATA_W_DFLT = 128;

    // Byte-enable width for a given data width.
    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    // Occupancy of one skid stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // main and skid empty
        ST_BUSY  = 2'd1,  // main holds a beat, skid empty
        ST_FULL  = 2'd2   // main and skid both hold beats
    } stage_state_e;

    // One stream beat at the default width; the top builds the same layout at DATA_W.
    typedef struct packed {
        logic [DATA_W_DFLT-1:0]   data;
        logic [DATA_W_DFLT/8-1:0] keep;
        logic                     last;
    } beat_t;

endpackage

// File: rtl/axis_skid_stage.sv
// One full-throughput skid-buffer stage: a main register that drives the
// output and a skid register that catches the beat in flight when the
// downstream stalls. in_ready and out_valid both come straight from flops.
module axis_skid_stage
    import axis_skid_pkg::*;
#(
    parameter type beat_t = logic
) (
    input  logic  clk,
    input  logic  rstn,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready,
    output logic  busy
);

    stage_state_e state_q, state_d;
    beat_t        main_q, skid_q;
    logic         ready_q;
    logic         in_xfer, out_acc;
    logic         load_main_in, load_main_skid, load_skid;

    assign in_xfer   = in_valid && ready_q;
    assign out_acc   = (state_q != ST_EMPTY) && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_beat  = main_q;
    assign busy      = (state_q != ST_EMPTY);

    // Next state and register load selects from the two handshakes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_acc) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_acc) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_acc) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, payload registers and the registered upstream ready.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!rstn) begin
            // NOTE: payload registers are cleared too, so nothing stale is visible after reset.
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

endmodule

// File: rtl/axis_skid_pipe.sv
// AXI4-Stream pipeline slice: STAGES skid stages in series, or a plain
// wire-through when STAGES=0. Optional beat/packet counters on the output
// side are enabled by defining AXIS_SKID_PKT_CNT_EN.
module axis_skid_pipe
    import axis_skid_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int STAGES = 2
`ifdef AXIS_SKID_PKT_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic [keep_w(DATA_W)-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [keep_w(DATA_W)-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy
`ifdef AXIS_SKID_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic [CNT_W-1:0]          pkt_cnt
`endif
);

    localparam int KEEP_W   = keep_w(DATA_W);
    localparam int N_STAGES = (STAGES > STAGES_MAX) ? STAGES_MAX : STAGES;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } lane_beat_t;

    generate
        if (N_STAGES == 0) begin : g_bypass
            assign m_axis_tdata  = s_axis_tdata;
            assign m_axis_tkeep  = s_axis_tkeep;
            assign m_axis_tlast  = s_axis_tlast;
            assign m_axis_tvalid = s_axis_tvalid;
            assign s_axis_tready = m_axis_tready;
            assign busy          = 1'b0;
        end else begin : g_pipe
            // Link k is the input of stage k; link N_STAGES is m_axis.
            lane_beat_t          link_beat  [N_STAGES+1];
            logic                link_valid [N_STAGES+1];
            logic                link_ready [N_STAGES+1];
            logic [N_STAGES-1:0] stage_busy;

            assign link_beat[0]         = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
            assign link_valid[0]        = s_axis_tvalid;
            assign s_axis_tready        = link_ready[0];
            assign link_ready[N_STAGES] = m_axis_tready;

            for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
                axis_skid_stage #(
                    .beat_t(lane_beat_t)
                ) u_stage (
                    .clk      (clk),
                    .rstn     (rstn),
                    .in_beat  (link_beat[k]),
                    .in_valid (link_valid[k]),
                    .in_ready (link_ready[k]),
                    .out_beat (link_beat[k+1]),
                    .out_valid(link_valid[k+1]),
                    .out_ready(link_ready[k+1]),
                    .busy     (stage_busy[k])
                );
            end

            assign m_axis_tdata  = link_beat[N_STAGES].data;
            assign m_axis_tkeep  = link_beat[N_STAGES].keep;
            assign m_axis_tlast  = link_beat[N_STAGES].last;
            assign m_axis_tvalid = link_valid[N_STAGES];
            assign busy          = |stage_busy;
        end
    endgenerate

`ifdef AXIS_SKID_PKT_CNT_EN
    // Count beats and end-of-packet beats leaving on m_axis; both wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_skid_pipe.sv
// Directed and random checks of axis_skid_pipe (STAGES=2, DATA_W=64) plus a
// STAGES=0 wire-through instance. Counter checks run when
// AXIS_SKID_PKT_CNT_EN is defined.
module tb_axis_skid_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tvalid, m_tready;
    logic        busy;

    logic [63:0] z_s_tdata;
    logic [7:0]  z_s_tkeep;
    logic        z_s_tlast, z_s_tvalid, z_s_tready;
    logic [63:0] z_m_tdata;
    logic [7:0]  z_m_tkeep;
    logic        z_m_tlast, z_m_tvalid, z_m_tready;
    logic        z_busy;

`ifdef AXIS_SKID_PKT_CNT_EN
    logic [3:0] beat_cnt, pkt_cnt, z_beat_cnt, z_pkt_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    axis_skid_pipe #(
        .DATA_W(64),
        .STAGES(2)
`ifdef AXIS_SKID_PKT_CNT_EN
        , .CNT_W(4)
`endif
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .busy         (busy)
`ifdef AXIS_SKID_PKT_CNT_EN
        , .beat_cnt   (beat_cnt),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    axis_skid_pipe #(
        .DATA_W(64),
        .STAGES(0)
`ifdef AXIS_SKID_PKT_CNT_EN
        , .CNT_W(4)
`endif
    ) u_dut0 (
        .clk          (clk),
        .rstn         (rstn),
        .s_axis_tdata (z_s_tdata),
        .s_axis_tkeep (z_s_tkeep),
        .s_axis_tlast (z_s_tlast),
        .s_axis_tvalid(z_s_tvalid),
        .s_axis_tready(z_s_tready),
        .m_axis_tdata (z_m_tdata),
        .m_axis_tkeep (z_m_tkeep),
        .m_axis_tlast (z_m_tlast),
        .m_axis_tvalid(z_m_tvalid),
        .m_axis_tready(z_m_tready),
        .busy         (z_busy)
`ifdef AXIS_SKID_PKT_CNT_EN
        , .beat_cnt   (z_beat_cnt),
        .pkt_cnt      (z_pkt_cnt)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } tb_beat_t;

    typedef struct {
        logic        s_valid;
        logic [63:0] s_data;
        logic        m_ready;
        logic        exp_s_ready;
        logic        exp_m_valid;
        logic [63:0] exp_m_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        tb_beat_t q[$];
        tb_beat_t cur, exp_b, held;
        int sent, recv, cyc;
        logic hold_pending;

        rstn       = 1'b0;
        s_tdata    = '0;
        s_tkeep    = 8'hFF;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        z_s_tdata  = '0;
        z_s_tkeep  = '0;
        z_s_tlast  = 1'b0;
        z_s_tvalid = 1'b0;
        z_m_tready = 1'b0;

        // Stall-fill then drain, STAGES=2: 4 beats fit, then s_ready drops.
        vecs[0]  = '{1'b1, 64'h1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 64'h2, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
        vecs[2]  = '{1'b1, 64'h3, 1'b0, 1'b1, 1'b1, 64'h1, 1'b1};
        vecs[3]  = '{1'b1, 64'h4, 1'b0, 1'b1, 1'b1, 64'h1, 1'b1};
        vecs[4]  = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 64'h1, 1'b1};
        vecs[5]  = '{1'b1, 64'h5, 1'b1, 1'b0, 1'b1, 64'h1, 1'b1};
        vecs[6]  = '{1'b1, 64'h5, 1'b1, 1'b0, 1'b1, 64'h2, 1'b1};
        vecs[7]  = '{1'b1, 64'h5, 1'b1, 1'b1, 1'b1, 64'h3, 1'b1};
        vecs[8]  = '{1'b1, 64'h6, 1'b1, 1'b1, 1'b1, 64'h4, 1'b1};
        vecs[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h5, 1'b1};
        vecs[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h6, 1'b1};
        vecs[11] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};

        // Reset state.
        step();
        step();
        check("rst_s_ready", s_tready, 1'b0);
        check("rst_m_valid", m_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        step();
        check("rst_release_s_ready", s_tready, 1'b1);
        check("rst_release_m_valid", m_tvalid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            s_tvalid = vecs[i].s_valid;
            s_tdata  = vecs[i].s_data;
            m_tready = vecs[i].m_ready;
            check($sformatf("vec%0d_s_ready", i), s_tready, vecs[i].exp_s_ready);
            check($sformatf("vec%0d_m_valid", i), m_tvalid, vecs[i].exp_m_valid);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_m_valid)
                check($sformatf("vec%0d_m_data", i), m_tdata, vecs[i].exp_m_data);
            step();
        end

        // Continuous flow: 16 beats back-to-back, 2-cycle latency, 1 beat/clk.
        m_tready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            s_tvalid = (i < 16);
            s_tdata  = 64'(i + 1);
            check($sformatf("flow%0d_s_ready", i), s_tready, 1'b1);
            check($sformatf("flow%0d_m_valid", i), m_tvalid, (i >= 2));
            if (i >= 2) check($sformatf("flow%0d_m_data", i), m_tdata, 64'(i - 1));
            step();
        end
        s_tvalid = 1'b0;

        // Reset with three beats held.
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hA1 + 64'(i);
            check($sformatf("hold%0d_s_ready", i), s_tready, 1'b1);
            step();
        end
        s_tvalid = 1'b0;
        check("hold_busy", busy, 1'b1);
        check("hold_m_data", m_tdata, 64'hA1);
        rstn = 1'b0;
        step();
        check("midrst_m_valid", m_tvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_s_ready", s_tready, 1'b0);
        rstn = 1'b1;
        step();
        check("midrst_release_s_ready", s_tready, 1'b1);
        check("midrst_release_m_valid", m_tvalid, 1'b0);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 64'h77;
        step();
        s_tvalid = 1'b0;
        check("post_rst_c1_m_valid", m_tvalid, 1'b0);
        step();
        check("post_rst_c2_m_valid", m_tvalid, 1'b1);
        check("post_rst_c2_m_data", m_tdata, 64'h77);
        step();
        check("post_rst_c3_m_valid", m_tvalid, 1'b0);

        // STAGES=0 wire-through.
        z_s_tvalid = 1'b1;
        z_s_tdata  = 64'hAB;
        z_s_tkeep  = 8'h0F;
        z_s_tlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            z_m_tready = i[0];
            #1;
            check($sformatf("byp%0d_m_valid", i), z_m_tvalid, 1'b1);
            check($sformatf("byp%0d_m_data", i), {z_m_tdata, z_m_tkeep, z_m_tlast}, {64'hAB, 8'h0F, 1'b1});
            check($sformatf("byp%0d_s_ready", i), z_s_tready, i[0]);
        end
        z_s_tvalid = 1'b0;
        #1;
        check("byp_idle_m_valid", z_m_tvalid, 1'b0);

`ifdef AXIS_SKID_PKT_CNT_EN
        // 17 beats in packets of 5, 6, 6 with a 4-bit counter.
        reset_dut();
        check("cnt_rst_beat", beat_cnt, 4'd0);
        check("cnt_rst_pkt", pkt_cnt, 4'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'(i);
            s_tlast  = (i == 4) || (i == 10) || (i == 16);
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("cnt_beat_wrap", beat_cnt, 4'd1);
        check("cnt_pkt", pkt_cnt, 4'd3);
`endif

        // Random backpressure with a scoreboard.
        reset_dut();
        sent = 0;
        recv = 0;
        cyc  = 0;
        hold_pending = 1'b0;
        held = '0;
        cur  = '0;
        while (recv < 10000 && cyc < 60000) begin
            if (hold_pending) begin
                check("rnd_valid_held", m_tvalid, 1'b1);
                check("rnd_beat_stable", {m_tdata, m_tkeep, m_tlast}, held);
            end
            if (!(s_tvalid && !s_tready)) begin
                if (sent < 10000 && $urandom_range(0, 1) == 1) begin
                    cur.data = {$urandom, $urandom};
                    cur.keep = 8'($urandom);
                    cur.last = 1'($urandom);
                    s_tvalid = 1'b1;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            s_tdata  = cur.data;
            s_tkeep  = cur.keep;
            s_tlast  = cur.last;
            m_tready = 1'($urandom_range(0, 1));
            if (s_tvalid && s_tready) begin
                q.push_back(cur);
                sent++;
            end
            if (m_tvalid && m_tready) begin
                check("rnd_sb_nonempty", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    exp_b = q.pop_front();
                    check($sformatf("rnd_beat%0d", recv), {m_tdata, m_tkeep, m_tlast}, exp_b);
                end
                recv++;
            end
            hold_pending = m_tvalid && !m_tready;
            held = {m_tdata, m_tkeep, m_tlast};
            step();
            cyc++;
        end
        s_tvalid = 1'b0;
        check("rnd_all_received", recv, 10000);
        check("rnd_sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
